// File: rtl/lsu_mem_master_if.sv
// Core-side op/result handshake and single-port data memory bus of the load/store unit.
// master = the LSU, slave = the core and memory side facing it.
interface lsu_mem_master_if;
  logic        op_valid;
  logic        op_ready;
  logic        op_we;
  logic [1:0]  op_size;
  logic        op_unsigned;
  logic [31:0] op_adr;
  logic [31:0] op_wdata;
  logic        res_valid;
  logic [31:0] res_data;
  logic [1:0]  res_err_code;
  logic        r_v;
  logic        w_v;
  logic [31:0] adr;
  logic [31:0] data;
  logic [3:0]  strobe;
  logic [31:0] resp;
  logic        resp_valid;
  logic        resp_error;

  modport master (
    input  op_valid, op_we, op_size, op_unsigned, op_adr, op_wdata,
    input  resp, resp_valid, resp_error,
    output op_ready, res_valid, res_data, res_err_code,
    output r_v, w_v, adr, data, strobe
  );

  modport slave (
    output op_valid, op_we, op_size, op_unsigned, op_adr, op_wdata,
    output resp, resp_valid, resp_error,
    input  op_ready, res_valid, res_data, res_err_code,
    input  r_v, w_v, adr, data, strobe
  );
endinterface

// File: rtl/lsu_mem_master.sv
// Load/store initiator: one op at a time, alignment check, strobe/lane build, load extension.
// Optional read-wait abort (result code 11) is built only when LSU_TIMEOUT_EN is defined.
module lsu_mem_master #(
  parameter int xlen = 32
`ifdef LSU_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 16
`endif
) (
  input  logic              clk,
  input  logic              rst,
  lsu_mem_master_if.master  bus
);

  typedef enum logic [1:0] {IDLE, WR, RD, DONE} state_e;

  localparam logic [1:0] ERR_OK    = 2'b00;
  localparam logic [1:0] ERR_ALIGN = 2'b01;
  localparam logic [1:0] ERR_BUS   = 2'b10;
`ifdef LSU_TIMEOUT_EN
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;
`endif

  state_e            state_q, state_d;
  logic              op_ready_q, op_ready_d;
  logic              r_v_q, r_v_d;
  logic              w_v_q, w_v_d;
  logic [31:0]       adr_q, adr_d;
  logic [xlen-1:0]   data_q, data_d;
  logic [3:0]        strobe_q, strobe_d;
  logic              res_valid_q, res_valid_d;
  logic [xlen-1:0]   res_data_q, res_data_d;
  logic [1:0]        res_err_q, res_err_d;
  logic [1:0]        size_q, size_d;
  logic [1:0]        off_q, off_d;
  logic              uns_q, uns_d;
`ifdef LSU_TIMEOUT_EN
  logic [7:0]        wait_q, wait_d;
`endif

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    return (size == 2'b11) || (size == 2'b01 && off[0]) || (size == 2'b10 && off != 2'b00);
  endfunction

  function automatic logic [3:0] strobe_of(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   return 4'b0001 << off;
      2'b01:   return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [xlen-1:0] lanes_of(input logic [1:0] size, input logic [xlen-1:0] wdata);
    case (size)
      2'b00:   return {4{wdata[7:0]}};
      2'b01:   return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

  // Addressed byte/half is shifted down to bit 0, then sign- or zero-filled.
  function automatic logic [xlen-1:0] extract(input logic [1:0] size, input logic [1:0] off,
                                              input logic uns, input logic [xlen-1:0] resp);
    logic [xlen-1:0] sh;
    sh = resp >> {off, 3'b000};
    case (size)
      2'b00:   return {{(xlen-8){~uns & sh[7]}}, sh[7:0]};
      2'b01:   return {{(xlen-16){~uns & sh[15]}}, sh[15:0]};
      default: return sh;
    endcase
  endfunction

  always_comb begin
    state_d     = state_q;
    op_ready_d  = op_ready_q;
    r_v_d       = r_v_q;
    w_v_d       = w_v_q;
    adr_d       = adr_q;
    data_d      = data_q;
    strobe_d    = strobe_q;
    res_valid_d = 1'b0;
    res_data_d  = res_data_q;
    res_err_d   = res_err_q;
    size_d      = size_q;
    off_d       = off_q;
    uns_d       = uns_q;
`ifdef LSU_TIMEOUT_EN
    wait_d      = wait_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.op_valid) begin
          size_d     = bus.op_size;
          off_d      = bus.op_adr[1:0];
          uns_d      = bus.op_unsigned;
          op_ready_d = 1'b0;
          if (misaligned(bus.op_size, bus.op_adr[1:0])) begin
            state_d     = DONE;
            res_valid_d = 1'b1;
            res_data_d  = '0;
            res_err_d   = ERR_ALIGN;
          end else begin
            adr_d    = {bus.op_adr[31:2], 2'b00};
            strobe_d = strobe_of(bus.op_size, bus.op_adr[1:0]);
            if (bus.op_we) begin
              data_d  = lanes_of(bus.op_size, bus.op_wdata);
              w_v_d   = 1'b1;
              state_d = WR;
            end else begin
              r_v_d   = 1'b1;
              state_d = RD;
`ifdef LSU_TIMEOUT_EN
              wait_d  = '0;
`endif
            end
          end
        end
      end
      WR: begin
        w_v_d       = 1'b0;
        state_d     = DONE;
        res_valid_d = 1'b1;
        res_data_d  = '0;
        res_err_d   = bus.resp_error ? ERR_BUS : ERR_OK;
      end
      RD: begin
        // A response arriving on the limit cycle still wins over the abort.
        if (bus.resp_valid) begin
          r_v_d       = 1'b0;
          state_d     = DONE;
          res_valid_d = 1'b1;
          res_err_d   = bus.resp_error ? ERR_BUS : ERR_OK;
          res_data_d  = bus.resp_error ? '0 : extract(size_q, off_q, uns_q, bus.resp);
        end
`ifdef LSU_TIMEOUT_EN
        else begin
          wait_d = wait_q + 8'd1;
          if (wait_d == 8'(TIMEOUT_CYCLES)) begin
            r_v_d       = 1'b0;
            state_d     = DONE;
            res_valid_d = 1'b1;
            res_data_d  = '0;
            res_err_d   = ERR_TIMEOUT;
          end
        end
`endif
      end
      DONE: begin
        state_d    = IDLE;
        op_ready_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      op_ready_q  <= 1'b1;
      r_v_q       <= 1'b0;
      w_v_q       <= 1'b0;
      adr_q       <= '0;
      data_q      <= '0;
      strobe_q    <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_err_q   <= ERR_OK;
    end else begin
      state_q     <= state_d;
      op_ready_q  <= op_ready_d;
      r_v_q       <= r_v_d;
      w_v_q       <= w_v_d;
      adr_q       <= adr_d;
      data_q      <= data_d;
      strobe_q    <= strobe_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_err_q   <= res_err_d;
    end
    size_q <= size_d;
    off_q  <= off_d;
    uns_q  <= uns_d;
`ifdef LSU_TIMEOUT_EN
    wait_q <= wait_d;
`endif
  end

  assign bus.op_ready     = op_ready_q;
  assign bus.r_v          = r_v_q;
  assign bus.w_v          = w_v_q;
  assign bus.adr          = adr_q;
  assign bus.data         = data_q;
  assign bus.strobe       = strobe_q;
  assign bus.res_valid    = res_valid_q;
  assign bus.res_data     = res_data_q;
  assign bus.res_err_code = res_err_q;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Self-checking bench for lsu_mem_master: directed cases with literal expectations,
// then random ops against a behavioural model; a memory responder answers reads.
module tb_lsu_mem_master;
  logic clk = 1'b0;
  logic rst = 1'b1;
  initial forever #5 clk = ~clk;

  lsu_mem_master_if bus();

`ifdef LSU_TIMEOUT_EN
  localparam int TO = 4;
  lsu_mem_master #(.xlen(32), .TIMEOUT_CYCLES(TO)) dut (.clk(clk), .rst(rst), .bus(bus));
`else
  lsu_mem_master #(.xlen(32)) dut (.clk(clk), .rst(rst), .bus(bus));
`endif

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic rst_at_edge = 1'b0;

  logic        pending = 1'b0;
  logic [31:0] exp_adr, exp_wdata, exp_res;
  logic [3:0]  exp_strobe;
  logic [1:0]  exp_code;
  int          exp_lat, exp_rcyc, exp_wcyc;

  logic        lit_en = 1'b0;
  logic [31:0] lit_res, lit_wdata;
  logic [3:0]  lit_strobe;
  logic [1:0]  lit_code;
  int          lit_lat;

  int          mem_delay = 0;
  logic [31:0] mem_word = 32'h0;
  logic        mem_err = 1'b0;

  int acc_cyc = 0;
  int rcyc = 0;
  int wcyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
    rst_at_edge = rst;
  end

  // Memory: answers a read after mem_delay extra cycles, flags store errors during the write cycle.
  initial begin
    int run;
    run = 0;
    bus.resp_valid = 1'b0;
    bus.resp_error = 1'b0;
    bus.resp = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.r_v) begin
        run++;
        bus.resp_valid = (run == mem_delay + 1);
        bus.resp_error = bus.resp_valid ? mem_err : 1'b0;
        bus.resp       = bus.resp_valid ? mem_word : $urandom();
      end else begin
        run = 0;
        bus.resp_valid = 1'b0;
        bus.resp_error = bus.w_v ? mem_err : 1'b0;
        bus.resp       = $urandom();
      end
    end
  end

  // Compare process: checks every cycle's outputs against the model expectations.
  initial forever begin
    @(negedge clk);
    if (rst_at_edge) begin
      chk("reset_ctl", 32'({bus.op_ready, bus.r_v, bus.w_v, bus.res_valid, bus.res_err_code}), 32'h20);
      chk("reset_adr", bus.adr, 32'h0);
      chk("reset_data", bus.data, 32'h0);
      chk("reset_strobe", 32'(bus.strobe), 32'h0);
      chk("reset_res_data", bus.res_data, 32'h0);
    end else begin
      if (bus.r_v || bus.w_v || bus.res_valid) chk("activity_needs_op", 32'(pending), 32'h1);
      if (bus.r_v || bus.w_v) chk("rv_wv_exclusive", 32'(bus.r_v & bus.w_v), 32'h0);
      if (bus.w_v) begin
        wcyc++;
        chk("wr_adr", bus.adr, exp_adr);
        chk("wr_data", bus.data, exp_wdata);
        chk("wr_strobe", 32'(bus.strobe), 32'(exp_strobe));
        if (lit_en) begin
          chk("lit_wr_strobe", 32'(bus.strobe), 32'(lit_strobe));
          chk("lit_wr_data", bus.data, lit_wdata);
        end
      end
      if (bus.r_v) begin
        rcyc++;
        chk("rd_adr", bus.adr, exp_adr);
        chk("rd_strobe", 32'(bus.strobe), 32'(exp_strobe));
        if (lit_en) chk("lit_rd_strobe", 32'(bus.strobe), 32'(lit_strobe));
      end
      if (bus.res_valid) begin
        chk("res_data", bus.res_data, exp_res);
        chk("res_code", 32'(bus.res_err_code), 32'(exp_code));
        chk("latency", 32'(cyc - acc_cyc), 32'(exp_lat));
        chk("rd_cycles", 32'(rcyc), 32'(exp_rcyc));
        chk("wr_cycles", 32'(wcyc), 32'(exp_wcyc));
        if (lit_en) begin
          chk("lit_res_data", bus.res_data, lit_res);
          chk("lit_res_code", 32'(bus.res_err_code), 32'(lit_code));
          chk("lit_latency", 32'(cyc - acc_cyc), 32'(lit_lat));
        end
      end
      if (bus.op_valid && bus.op_ready) begin
        acc_cyc = cyc;
        rcyc = 0;
        wcyc = 0;
      end
    end
  end

  // Behavioural model of one op: what the bus and the result must look like.
  task automatic set_expect(input logic we, input logic [1:0] size, input logic uns,
                            input logic [31:0] adr, input logic [31:0] wdata,
                            input logic [31:0] word, input logic err, input int delay);
    int off;
    int v;
    logic mis;
    logic timed_out;
    logic [31:0] sh;
    off = int'(adr % 4);
    mis = (size == 2'd3) || (size == 2'd1 && off % 2 == 1) || (size == 2'd2 && off != 0);
    timed_out = 1'b0;
`ifdef LSU_TIMEOUT_EN
    timed_out = (delay >= TO);
`endif
    exp_adr    = adr - 32'(off);
    exp_strobe = (size == 2'd0) ? 4'(1 << off) : (size == 2'd1) ? 4'(3 << off) : 4'hF;
    exp_wdata  = (size == 2'd0) ? (wdata % 256) * 32'h01010101 :
                 (size == 2'd1) ? (wdata % 65536) * 32'h00010001 : wdata;
    exp_res = 32'h0;
    exp_rcyc = 0;
    exp_wcyc = 0;
    if (mis) begin
      exp_code = 2'd1;
      exp_lat  = 1;
    end else if (we) begin
      exp_code = err ? 2'd2 : 2'd0;
      exp_lat  = 2;
      exp_wcyc = 1;
    end else if (timed_out) begin
`ifdef LSU_TIMEOUT_EN
      exp_rcyc = TO;
      exp_lat  = TO + 1;
`endif
      exp_code = 2'd3;
    end else begin
      exp_rcyc = delay + 1;
      exp_lat  = delay + 2;
      exp_code = err ? 2'd2 : 2'd0;
      if (!err) begin
        sh = word >> (8 * off);
        if (size == 2'd0) begin
          v = int'(sh % 256);
          if (!uns && v >= 128) v = v - 256;
          exp_res = 32'(v);
        end else if (size == 2'd1) begin
          v = int'(sh % 65536);
          if (!uns && v >= 32768) v = v - 65536;
          exp_res = 32'(v);
        end else begin
          exp_res = word;
        end
      end
    end
    mem_delay = delay;
    mem_word  = word;
    mem_err   = err;
  endtask

  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] adr, input logic [31:0] wdata);
    int guard;
    guard = 0;
    while (!bus.op_ready && guard < 50) begin
      @(posedge clk);
      #1;
      guard++;
    end
    chk("op_ready_before_issue", 32'(bus.op_ready), 32'h1);
    bus.op_valid    = 1'b1;
    bus.op_we       = we;
    bus.op_size     = size;
    bus.op_unsigned = uns;
    bus.op_adr      = adr;
    bus.op_wdata    = wdata;
    pending         = 1'b1;
    @(posedge clk);
    #1;
    bus.op_valid    = 1'b0;
    bus.op_we       = 1'($urandom());
    bus.op_size     = 2'($urandom());
    bus.op_unsigned = 1'($urandom());
    bus.op_adr      = $urandom();
    bus.op_wdata    = $urandom();
    chk("op_ready_drops", 32'(bus.op_ready), 32'h0);
  endtask

  task automatic do_op(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] adr, input logic [31:0] wdata,
                       input logic [31:0] word, input logic err, input int delay);
    int guard;
    logic seen;
    set_expect(we, size, uns, adr, wdata, word, err, delay);
    issue(we, size, uns, adr, wdata);
    seen = 1'b0;
    guard = 0;
    while (!seen && guard < 200) begin
      @(negedge clk);
      seen = bus.res_valid;
      guard++;
    end
    chk("res_valid_seen", 32'(seen), 32'h1);
    @(posedge clk);
    #1;
    pending = 1'b0;
    lit_en  = 1'b0;
  endtask

  task automatic set_lit(input logic [31:0] res, input logic [1:0] code, input logic [3:0] strobe,
                         input logic [31:0] wdata, input int lat);
    lit_en     = 1'b1;
    lit_res    = res;
    lit_code   = code;
    lit_strobe = strobe;
    lit_wdata  = wdata;
    lit_lat    = lat;
  endtask

  initial begin
    #2000000;
    $display("FAIL global_watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    bus.op_valid    = 1'b0;
    bus.op_we       = 1'b0;
    bus.op_size     = 2'd0;
    bus.op_unsigned = 1'b0;
    bus.op_adr      = 32'h0;
    bus.op_wdata    = 32'h0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    set_lit(32'hFFFFFFFF, 2'b00, 4'b0100, 32'h0, 2);
    do_op(1'b0, 2'd0, 1'b0, 32'h00020002, 32'h0, 32'h80FF7F00, 1'b0, 0);
    set_lit(32'h000000FF, 2'b00, 4'b0100, 32'h0, 4);
    do_op(1'b0, 2'd0, 1'b1, 32'h00020002, 32'h0, 32'h80FF7F00, 1'b0, 2);
    set_lit(32'h0, 2'b00, 4'b1100, 32'hABCDABCD, 2);
    do_op(1'b1, 2'd1, 1'b0, 32'h00020002, 32'h1234ABCD, 32'h0, 1'b0, 0);
    set_lit(32'h0, 2'b01, 4'b0000, 32'h0, 1);
    do_op(1'b0, 2'd2, 1'b0, 32'h00020001, 32'h0, 32'h11223344, 1'b0, 0);
    set_lit(32'h0, 2'b01, 4'b0000, 32'h0, 1);
    do_op(1'b1, 2'd3, 1'b0, 32'h00020000, 32'h55AA55AA, 32'h0, 1'b0, 0);
    set_lit(32'h0, 2'b10, 4'b1111, 32'h0, 3);
    do_op(1'b0, 2'd2, 1'b0, 32'h00030000, 32'h0, 32'hCAFEF00D, 1'b1, 1);
    set_lit(32'h0, 2'b10, 4'b0001, 32'h77777777, 2);
    do_op(1'b1, 2'd0, 1'b0, 32'h00030004, 32'h00000077, 32'h0, 1'b1, 0);
    set_lit(32'hFFFF8001, 2'b00, 4'b0011, 32'h0, 2);
    do_op(1'b0, 2'd1, 1'b0, 32'h00000010, 32'h0, 32'h12348001, 1'b0, 0);

    // Reset while the read is still waiting: no result may follow.
    set_expect(1'b0, 2'd2, 1'b0, 32'h00040000, 32'h0, 32'h0, 1'b0, 1000);
    issue(1'b0, 2'd2, 1'b0, 32'h00040000, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    pending = 1'b0;
    repeat (6) @(posedge clk);
    #1;

`ifdef LSU_TIMEOUT_EN
    set_lit(32'h0, 2'b11, 4'b1111, 32'h0, 5);
    do_op(1'b0, 2'd2, 1'b0, 32'h00000100, 32'h0, 32'hDEADBEEF, 1'b0, 1000);
    set_lit(32'hDEADBEEF, 2'b00, 4'b1111, 32'h0, 5);
    do_op(1'b0, 2'd2, 1'b0, 32'h00000100, 32'h0, 32'hDEADBEEF, 1'b0, 3);
`endif

    for (int i = 0; i < 60; i++) begin
      logic [31:0] a;
      int d;
      a = $urandom();
      if ($urandom_range(0, 1) == 0) a = a & 32'hFFFFFFFC;
`ifdef LSU_TIMEOUT_EN
      d = int'($urandom_range(0, 6));
`else
      d = int'($urandom_range(0, 5));
`endif
      do_op(1'($urandom()), 2'($urandom_range(0, 3)), 1'($urandom()), a, $urandom(), $urandom(),
            ($urandom_range(0, 7) == 0), d);
    end

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
